vga_system_multi_timer: RTL and testbench

Parametrised multi-channel interval timer on the Avalon-MM slave bus of the VGA system, the successor to the single-channel 16-bit-bus timer. It provides NUM_CH independent down-counters of CNT_W bits, each with a period, snapshot, one-shot or continuous mode and per-channel interrupt enable. A global pending register with write-1-to-clear and a single combined `irq` output serve the Nios II interrupt controller.

---
 rtl/vga_timer_pkg.sv | 16 +
 rtl/vga_timer_channel.sv | 53 +++++
 rtl/vga_system_multi_timer.sv | 88 ++++++++
 tb/tb_vga_system_multi_timer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vga_timer_pkg.sv
// vga_timer_pkg: register map and bit positions shared by the multi-channel timer.
package vga_timer_pkg;
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_ofs_e;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;
  localparam int CH_STRIDE  = 4;
endpackage

// File: rtl/vga_timer_channel.sv
// vga_timer_channel: one down-counter with period, control, snapshot and TO/RUN flags.
module vga_timer_channel
  import vga_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 2499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic             clr,
  input  logic [31:0]      writedata,
  output logic [1:0]       status,
  output logic [1:0]       control,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq_ch
);
  logic [CNT_W-1:0] count;
  logic             to, run, wrap;
  assign wrap   = tick & run & (count == '0);
  assign status = {run, to};
  assign irq_ch = to & control[CTRL_ITO];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= CNT_W'(PERIOD_RST);
      period  <= CNT_W'(PERIOD_RST);
      snap    <= '0;
      control <= '0;
      to      <= 1'b0;
      run     <= 1'b0;
    end else begin
      if (wr_period) begin
        period <= writedata[CNT_W-1:0];
        count  <= writedata[CNT_W-1:0];
      end else if (tick & run) begin
        count <= wrap ? period : count - CNT_W'(1);
      end
      run <= wr_period                            ? 1'b0 :
             (wr_control & writedata[CTRL_START]) ? 1'b1 :
             (wr_control & writedata[CTRL_STOP])  ? 1'b0 :
             (wrap & ~control[CTRL_CONT])         ? 1'b0 : run;
      // a wrap in the same cycle as a clear keeps the event
      to <= wrap | (to & ~(wr_status | clr));
      if (wr_control) control <= writedata[1:0];
      if (wr_snap) snap <= count;
    end
  end
endmodule

// File: rtl/vga_system_multi_timer.sv
// vga_system_multi_timer: NUM_CH Avalon-MM interval timers with shared pending/irq.
// Define VGA_TIMER_PRESCALE_EN to add the shared 16-bit tick prescaler.
module vga_system_multi_timer
  import vga_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 2499999,
  localparam int ADDR_W    = $clog2(NUM_CH*4+2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);
  localparam int PEND_A = NUM_CH * CH_STRIDE;
  localparam int PRE_A  = PEND_A + 1;
  logic              wr, wr_pend, tick;
  logic [NUM_CH-1:0] irq_ch, pend;
  logic [1:0]        status  [NUM_CH];
  logic [1:0]        control [NUM_CH];
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [CNT_W-1:0]  snap    [NUM_CH];
  logic [31:0]       presc_rd, rd_next;
  reg_ofs_e          ofs;
  assign wr      = chipselect & ~write_n;
  assign wr_pend = wr & (address == ADDR_W'(PEND_A));
  assign ofs     = reg_ofs_e'(address[1:0]);
  assign irq     = |irq_ch;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel     = wr & ((address >> 2) == ADDR_W'(c));
    assign pend[c] = status[c][STAT_TO];
    vga_timer_channel #(.CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .wr_status  (sel & (ofs == REG_STATUS)),
      .wr_control (sel & (ofs == REG_CONTROL)),
      .wr_period  (sel & (ofs == REG_PERIOD)),
      .wr_snap    (sel & (ofs == REG_SNAP)),
      .clr        (wr_pend & writedata[c]),
      .writedata  (writedata),
      .status     (status[c]),
      .control    (control[c]),
      .period     (period[c]),
      .snap       (snap[c]),
      .irq_ch     (irq_ch[c])
    );
  end
`ifdef VGA_TIMER_PRESCALE_EN
  logic [15:0] presc, pcnt;
  assign tick     = (pcnt == presc);
  assign presc_rd = 32'(presc);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      pcnt  <= '0;
    end else if (wr & (address == ADDR_W'(PRE_A))) begin
      presc <= writedata[15:0];
      pcnt  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
    end
  end
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++)
      if ((address >> 2) == ADDR_W'(c))
        rd_next = ofs == REG_STATUS  ? 32'(status[c])  :
                  ofs == REG_CONTROL ? 32'(control[c]) :
                  ofs == REG_PERIOD  ? 32'(period[c])  : 32'(snap[c]);
    if (address == ADDR_W'(PEND_A)) rd_next = 32'(pend);
    if (address == ADDR_W'(PRE_A)) rd_next = presc_rd;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else readdata <= rd_next;
  end
endmodule

// File: tb/tb_vga_system_multi_timer.sv
// tb_vga_system_multi_timer: directed table plus timing sequences for the multi-channel timer.
module tb_vga_system_multi_timer;
  logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1, irq;
  logic [4:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  int          checks = 0, errors = 0;
`ifdef VGA_TIMER_PRESCALE_EN
  localparam int PS_FIRST = 6, PS_GAP = 5, PS_REG = 1;
`else
  localparam int PS_FIRST = 3, PS_GAP = 2, PS_REG = 0;
`endif
  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
  } vec_t;
  vec_t vecs [19];

  always #5 clk = ~clk;

  vga_system_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!irq && n < 200);
    if (!irq) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int n;
    vecs = '{
      '{1'b0, 5'd2,  32'd2499999}, '{1'b0, 5'd0,  32'd0}, '{1'b0, 5'd14, 32'd2499999},
      '{1'b0, 5'd11, 32'd0},       '{1'b0, 5'd16, 32'd0}, '{1'b0, 5'd17, 32'd0},
      '{1'b1, 5'd9,  32'hF},       '{1'b0, 5'd9,  32'h3}, '{1'b0, 5'd8,  32'h2},
      '{1'b1, 5'd9,  32'h8},       '{1'b0, 5'd8,  32'h0}, '{1'b0, 5'd9,  32'h0},
      '{1'b1, 5'd10, 32'h1234},    '{1'b0, 5'd10, 32'h1234}, '{1'b1, 5'd18, 32'hFFFF},
      '{1'b0, 5'd18, 32'h0},       '{1'b0, 5'd31, 32'h0}, '{1'b1, 5'd8,  32'h3},
      '{1'b0, 5'd8,  32'h0}
    };
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].w) wr_reg(vecs[i].a, vecs[i].d);
      else begin
        rd_reg(vecs[i].a, r);
        chk($sformatf("vec%0d", i), r, vecs[i].d);
      end
    end
    // channel 1 continuous, period 3
    wr_reg(5'd6, 32'd3);
    wr_reg(5'd5, 32'h7);
    wait_irq(n);
    chk("cont_first", 32'(n), 32'd4);
    rd_reg(5'd16, r);
    chk("cont_pending", r, 32'h2);
    wr_reg(5'd16, 32'h2);
    chk("cont_irq_clr", 32'(irq), 32'd0);
    wait_irq(n);
    chk("cont_gap", 32'(n), 32'd2);
    wr_reg(5'd5, 32'h8);
    wr_reg(5'd16, 32'h2);
    chk("cont_stopped_irq", 32'(irq), 32'd0);
    // channel 0 one-shot, period 5
    wr_reg(5'd2, 32'd5);
    wr_reg(5'd1, 32'h5);
    wait_irq(n);
    chk("os_time", 32'(n), 32'd6);
    rd_reg(5'd0, r);
    chk("os_status", r, 32'h1);
    wr_reg(5'd3, 32'd0);
    rd_reg(5'd3, r);
    chk("os_reload", r, 32'd5);
    repeat (10) @(negedge clk);
    wr_reg(5'd3, 32'd0);
    rd_reg(5'd3, r);
    chk("os_hold", r, 32'd5);
    wr_reg(5'd0, 32'd0);
    chk("os_irq_clr", 32'(irq), 32'd0);
    rd_reg(5'd0, r);
    chk("os_status_clr", r, 32'h0);
    // W1C in the wrap cycle must not lose the event
    wr_reg(5'd2, 32'd3);
    wr_reg(5'd1, 32'h7);
    repeat (3) @(negedge clk);
    wr_reg(5'd16, 32'h1);
    chk("w1c_race_irq", 32'(irq), 32'd1);
    rd_reg(5'd16, r);
    chk("w1c_race_pend", r, 32'h1);
    wr_reg(5'd16, 32'h1);
    chk("w1c_clear_irq", 32'(irq), 32'd0);
    wr_reg(5'd1, 32'h8);
    // snapshot at count 10, then a mid-run period write
    wr_reg(5'd2, 32'd15);
    wr_reg(5'd1, 32'h4);
    repeat (5) @(negedge clk);
    wr_reg(5'd3, 32'd0);
    rd_reg(5'd3, r);
    chk("snap_10", r, 32'd10);
    wr_reg(5'd2, 32'd20);
    wr_reg(5'd3, 32'd0);
    rd_reg(5'd3, r);
    chk("period_load", r, 32'd20);
    rd_reg(5'd0, r);
    chk("period_stops_run", r, 32'h0);
    // channel 3 through the prescaler
    wr_reg(5'd17, 32'd1);
    wr_reg(5'd14, 32'd2);
    wr_reg(5'd13, 32'h7);
    wait_irq(n);
    chk("ps_first", 32'(n), 32'(PS_FIRST));
    wr_reg(5'd16, 32'h8);
    wait_irq(n);
    chk("ps_gap", 32'(n), 32'(PS_GAP));
    rd_reg(5'd17, r);
    chk("ps_reg", r, 32'(PS_REG));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
